mux_arb_rr: RTL and testbench

Parametrised, registered N-way selector with valid/ready handshaking; the sequential successor to the 16-bit 8:1 select tree. Merges NUM_IN producer streams of WIDTH-bit words into one registered output stream. Selection is either fixed, driven by a `sel` port as in the combinational mux, or round-robin arbitration among valid inputs. Used wherever several datapath sources must share one downstream consumer without dropping or duplicating words.

---
 rtl/mux_arb_rr_if.sv | 40 ++++
 rtl/mux_arb_rr.sv | 128 ++++++++++++
 tb/tb_mux_arb_rr.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mux_arb_rr_if.sv
// mux_arb_rr_if: handshake and data bundle for the mux_arb_rr selector.
// The in_last lane exists only when MUX_ARB_LOCK_EN is defined.
// master = producers/consumer side, slave = the selector itself.
interface mux_arb_rr_if #(
    parameter int WIDTH  = 16,
    parameter int NUM_IN = 8
);
    localparam int SEL_W = $clog2(NUM_IN);

    logic                      mode;
    logic [SEL_W-1:0]          sel;
    logic [NUM_IN*WIDTH-1:0]   in_data;
    logic [NUM_IN-1:0]         in_valid;
    logic [NUM_IN-1:0]         in_ready;
`ifdef MUX_ARB_LOCK_EN
    logic [NUM_IN-1:0]         in_last;
`endif
    logic [WIDTH-1:0]          out_data;
    logic [SEL_W-1:0]          out_sel;
    logic                      out_valid;
    logic                      out_ready;

    modport master (
        output mode, sel, in_data, in_valid,
`ifdef MUX_ARB_LOCK_EN
        output in_last,
`endif
        output out_ready,
        input  in_ready, out_data, out_sel, out_valid
    );

    modport slave (
        input  mode, sel, in_data, in_valid,
`ifdef MUX_ARB_LOCK_EN
        input  in_last,
`endif
        input  out_ready,
        output in_ready, out_data, out_sel, out_valid
    );
endinterface

// File: rtl/mux_arb_rr.sv
// mux_arb_rr: registered NUM_IN-way selector with valid/ready handshaking.
// Fixed selection via sel (mode=0) or round-robin among valid inputs (mode=1).
// Optional packet lock (hold the grant until in_last) with MUX_ARB_LOCK_EN.
module mux_arb_rr #(
    parameter int WIDTH  = 16,
    parameter int NUM_IN = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    mux_arb_rr_if.slave bus
);
    localparam int SEL_W = $clog2(NUM_IN);
    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_IN - 1);

    logic [SEL_W-1:0]  ptr;
    logic              load;
    logic              found;
    logic              grant;
    logic [SEL_W-1:0]  grant_idx;
    logic [NUM_IN-1:0] elig;
    logic [WIDTH-1:0]  chan [NUM_IN];
`ifdef MUX_ARB_LOCK_EN
    logic              lock;
    logic [SEL_W-1:0]  lock_idx;
`endif

    // Output register may take a new word when empty or being drained.
    always_comb begin
        load = ~bus.out_valid | bus.out_ready;
    end

    // Unpack the flat input bus into per-channel words.
    always_comb begin
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            chan[i] = bus.in_data[i*WIDTH +: WIDTH];
        end
    end

    // Channels allowed to win this cycle.
    always_comb begin
        elig = '0;
        if (bus.mode) begin
            elig = '1;
        end else if (int'(bus.sel) < NUM_IN) begin
            elig[bus.sel] = 1'b1;
        end
`ifdef MUX_ARB_LOCK_EN
        if (lock) begin
            elig = '0;
            elig[lock_idx] = 1'b1;
        end
`endif
        elig = elig & bus.in_valid;
    end

    // Scan from ptr with wrap at NUM_IN; fixed/locked sets hold one bit so the scan order is moot.
    always_comb begin
        int unsigned      idx;
        logic [SEL_W-1:0] idx_s;
        idx       = 0;
        idx_s     = '0;
        found     = 1'b0;
        grant_idx = '0;
        for (int unsigned k = 0; k < NUM_IN; k++) begin
            idx = 32'(ptr) + k;
            if (idx >= NUM_IN) begin
                idx = idx - NUM_IN;
            end
            idx_s = SEL_W'(idx);
            if (!found && elig[idx_s]) begin
                found     = 1'b1;
                grant_idx = idx_s;
            end
        end
    end

    // Grant and per-channel accept strobe; nothing is accepted in reset.
    always_comb begin
        grant        = rst_n & load & found;
        bus.in_ready = '0;
        if (grant) begin
            bus.in_ready[grant_idx] = 1'b1;
        end
    end

    // Output register: load granted word, or drop valid when drained with no grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_sel   <= '0;
        end else if (load) begin
            if (grant) begin
                bus.out_valid <= 1'b1;
                bus.out_data  <= chan[grant_idx];
                bus.out_sel   <= grant_idx;
            end else begin
                bus.out_valid <= 1'b0;
            end
        end
    end

    // Round-robin pointer advances past each round-robin winner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (grant && bus.mode) begin
            ptr <= (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
        end
    end

`ifdef MUX_ARB_LOCK_EN
    // Packet lock: hold the winner until it presents in_last.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock     <= 1'b0;
            lock_idx <= '0;
        end else if (grant) begin
            if (bus.in_last[grant_idx]) begin
                lock <= 1'b0;
            end else begin
                lock     <= 1'b1;
                lock_idx <= grant_idx;
            end
        end
    end
`endif
endmodule

// File: tb/tb_mux_arb_rr.sv
// tb_mux_arb_rr: scoreboard bench for mux_arb_rr (NUM_IN=8 main, NUM_IN=5 wrap).
// Define MUX_ARB_LOCK_EN to exercise the packet-lock feature.
module tb_mux_arb_rr;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    mux_arb_rr_if #(.WIDTH(16), .NUM_IN(8)) bus8 ();
    mux_arb_rr_if #(.WIDTH(16), .NUM_IN(5)) bus5 ();

    mux_arb_rr #(.WIDTH(16), .NUM_IN(8)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8.slave)
    );

    mux_arb_rr #(.WIDTH(16), .NUM_IN(5)) u_dut5 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus5.slave)
    );

    int errors   = 0;
    int n_checks = 0;

    // Reference model state for the 8-way instance.
    int          ptr_m      = 0;
    bit          ov_m       = 1'b0;
    bit          lock_m     = 1'b0;
    int          lock_idx_m = 0;
    logic [19:0] sb [$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic fill_data();
        for (int i = 0; i < 8; i++) begin
            bus8.in_data[i*16 +: 16] = 16'($urandom);
        end
    endtask

    // One cycle on the 8-way instance: predict grant, push to scoreboard, compare after the edge.
    task automatic step();
        logic [7:0] el;
        logic [7:0] rdy_m;
        bit         load_m;
        bit         hit;
        int         g;
        #1;
        load_m = !ov_m || bus8.out_ready;
        el = '0;
        if (bus8.mode) el = '1;
        else           el[bus8.sel] = 1'b1;
`ifdef MUX_ARB_LOCK_EN
        if (lock_m) begin
            el = '0;
            el[lock_idx_m] = 1'b1;
        end
`endif
        el = el & bus8.in_valid;
        hit = 1'b0;
        g   = 0;
        if (load_m) begin
            for (int k = 0; k < 8; k++) begin
                if (!hit && el[(ptr_m + k) % 8]) begin
                    hit = 1'b1;
                    g   = (ptr_m + k) % 8;
                end
            end
        end
        rdy_m = '0;
        if (hit) rdy_m[g] = 1'b1;
        check_eq("in_ready", 32'(bus8.in_ready), 32'(rdy_m));
        if (ov_m && bus8.out_ready && sb.size() > 0) void'(sb.pop_front());
        if (hit) sb.push_back({4'(g), bus8.in_data[g*16 +: 16]});
        @(posedge clk);
        #1;
        if (load_m) ov_m = hit;
        if (hit && bus8.mode) ptr_m = (g + 1) % 8;
`ifdef MUX_ARB_LOCK_EN
        if (hit) begin
            if (bus8.in_last[g]) begin
                lock_m = 1'b0;
            end else begin
                lock_m     = 1'b1;
                lock_idx_m = g;
            end
        end
`endif
        check_eq("out_valid", 32'(bus8.out_valid), 32'(ov_m));
        if (ov_m) begin
            check_eq("sb_depth", 32'(sb.size()), 32'd1);
            if (sb.size() > 0) begin
                check_eq("out_sel",  32'(bus8.out_sel),  32'(sb[0][19:16]));
                check_eq("out_data", 32'(bus8.out_data), 32'(sb[0][15:0]));
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus8.in_valid = '1;
        bus5.in_valid = '1;
        #1;
        check_eq("rst_in_ready",  32'(bus8.in_ready),  32'd0);
        check_eq("rst_out_valid", 32'(bus8.out_valid), 32'd0);
        check_eq("rst_out_data",  32'(bus8.out_data),  32'd0);
        check_eq("rst_out_sel",   32'(bus8.out_sel),   32'd0);
        check_eq("rst_in_ready5", 32'(bus5.in_ready),  32'd0);
        @(posedge clk);
        #1;
        check_eq("rst_hold_valid", 32'(bus8.out_valid), 32'd0);
        check_eq("rst_hold_ready", 32'(bus8.in_ready),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ptr_m      = 0;
        ov_m       = 1'b0;
        lock_m     = 1'b0;
        lock_idx_m = 0;
        sb.delete();
        bus8.in_valid = '0;
        bus5.in_valid = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        bus8.mode = 1'b0; bus8.sel = '0; bus8.in_data = '0; bus8.in_valid = '0; bus8.out_ready = 1'b1;
        bus5.mode = 1'b0; bus5.sel = '0; bus5.in_data = '0; bus5.in_valid = '0; bus5.out_ready = 1'b1;
`ifdef MUX_ARB_LOCK_EN
        bus8.in_last = '1;
        bus5.in_last = '1;
`endif
        do_reset();

        // First grant after reset comes from channel 0.
        bus8.mode = 1'b1; bus8.in_valid = '1; fill_data();
        step();
        check_eq("first_sel", 32'(bus8.out_sel), 32'd0);

        // Fixed selection.
        bus8.mode = 1'b0; bus8.sel = 3'd5; fill_data();
        bus8.in_data[5*16 +: 16] = 16'hA5A5;
        step();
        check_eq("fixed_data", 32'(bus8.out_data), 32'h0000A5A5);
        check_eq("fixed_sel",  32'(bus8.out_sel),  32'd5);
        for (int k = 0; k < 6; k++) begin
            bus8.sel = 3'($urandom_range(0, 7));
            fill_data();
            step();
        end

        // Round-robin fairness, all valid.
        do_reset();
        bus8.mode = 1'b1; bus8.in_valid = '1;
        for (int k = 0; k < 16; k++) begin
            fill_data();
            step();
            check_eq("rr_seq", 32'(bus8.out_sel), 32'(k % 8));
        end
        bus8.in_valid = 8'h44;
        for (int k = 0; k < 4; k++) begin
            fill_data();
            step();
            check_eq("rr_2_6", 32'(bus8.out_sel), (k % 2 == 1) ? 32'd6 : 32'd2);
        end

        // Backpressure then release with no bubble.
        bus8.in_valid = '1; fill_data();
        step();
        bus8.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            fill_data();
            bus8.sel = 3'($urandom_range(0, 7));
            bus8.mode = 1'($urandom_range(0, 1));
            step();
        end
        bus8.out_ready = 1'b1; bus8.mode = 1'b1; fill_data();
        step();
        step();

        // Random traffic.
        for (int k = 0; k < 80; k++) begin
            bus8.mode      = 1'($urandom_range(0, 1));
            bus8.sel       = 3'($urandom_range(0, 7));
            bus8.in_valid  = 8'($urandom);
            bus8.out_ready = ($urandom_range(0, 9) < 7);
`ifdef MUX_ARB_LOCK_EN
            bus8.in_last   = 8'($urandom);
`endif
            fill_data();
            step();
        end
        bus8.out_ready = 1'b1;

`ifdef MUX_ARB_LOCK_EN
        // Channel 3 holds the grant for a 4-word packet.
        do_reset();
        bus8.mode = 1'b1; bus8.in_last = '1; bus8.in_valid = 8'h04; fill_data();
        step();
        check_eq("lock_pre", 32'(bus8.out_sel), 32'd2);
        bus8.in_valid = '1;
        for (int k = 0; k < 5; k++) begin
            bus8.in_last = (k >= 3) ? 8'hFF : 8'hF7;
            fill_data();
            step();
            check_eq("lock_seq", 32'(bus8.out_sel), (k < 4) ? 32'd3 : 32'd4);
        end
        bus8.in_last = '1;
`endif

        // Five-channel instance: wrap at NUM_IN and out-of-range sel.
        do_reset();
        bus5.mode = 1'b1; bus5.in_valid = 5'h1F; bus5.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus5.in_data[i*16 +: 16] = 16'(16'h0500 + i);
        end
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            check_eq("wrap5_sel",  32'(bus5.out_sel),  32'(k % 5));
            check_eq("wrap5_data", 32'(bus5.out_data), 32'(16'h0500 + k % 5));
        end
        bus5.mode = 1'b0; bus5.sel = 3'd6;
        #1;
        check_eq("oob_ready", 32'(bus5.in_ready), 32'd0);
        @(posedge clk);
        #1;
        check_eq("oob_valid", 32'(bus5.out_valid), 32'd0);
        bus5.sel = 3'd3;
        @(posedge clk);
        #1;
        check_eq("fix5_valid", 32'(bus5.out_valid), 32'd1);
        check_eq("fix5_sel",   32'(bus5.out_sel),   32'd3);

        $display("Result: errors=%0d of %0d checks", errors, n_checks);
        $finish;
    end
endmodule
